// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter.
// State encoding, wait-counter width and the strobe bundle.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } mem_arb_st_t;

    localparam int MEM_ARB_WSW = 4;

    // Strobe bundle shaped like the ram0/ram1 control assigns.
    typedef struct packed {
        logic ce;
        logic oe;
        logic we;
    } mem_ctrl_t;

    function automatic logic [MEM_ARB_WSW-1:0] ws_load(
        input int ws
    );
        return MEM_ARB_WSW'(ws - 1);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and SRAM side bundle of the arbiter.
// master = requesters plus SRAM, slave = the arbiter.
interface mem_arb_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 23
);

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][7:0]        req_dati;
    logic [N_REQ-1:0]             ack;
    logic [7:0]                   dato;
    logic [ADDR_W-1:0]            ram_addr;
    logic [7:0]                   ram_dati;
    logic [7:0]                   ram_dato;
    logic                         ram_ce;
    logic                         ram_oe;
    logic                         ram_we;
    logic                         busy;

    modport master (
        output req,
        output req_we,
        output req_addr,
        output req_dati,
        output ram_dato,
        input  ack,
        input  dato,
        input  ram_addr,
        input  ram_dati,
        input  ram_ce,
        input  ram_oe,
        input  ram_we,
        input  busy
    );

    modport slave (
        input  req,
        input  req_we,
        input  req_addr,
        input  req_dati,
        input  ram_dato,
        output ack,
        output dato,
        output ram_addr,
        output ram_dati,
        output ram_ce,
        output ram_oe,
        output ram_we,
        output busy
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Round-robin picker over the non-urgent ports 1..N_REQ-1.
// Search starts just after last_grant and wraps back to port 1.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:1] req,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    logic [IW-1:0] p;

    // Walk from farthest to nearest so the nearest hit is kept.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        p     = '0;
        for (int off = N_REQ - 1; off >= 1; off--) begin
            p = IW'((int'(last_grant) - 1 + off)
                    % (N_REQ - 1) + 1);
            if (req[p]) begin
                grant = p;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Clocked arbiter for one external SRAM port.
// One grant at a time, SETUP/ACCESS/HOLD strobes, one-cycle ack.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 23,
    parameter int RD_WS  = 2,
    parameter int WR_WS  = 2
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [MEM_ARB_WSW-1:0] RD_LD = ws_load(RD_WS);
    localparam logic [MEM_ARB_WSW-1:0] WR_LD = ws_load(WR_WS);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
        $error("mem_arb: N_REQ must be 2..8");
    end
    if (RD_WS < 1 || RD_WS > 15) begin : g_bad_rd
        $error("mem_arb: RD_WS must be 1..15");
    end
    if (WR_WS < 1 || WR_WS > 15) begin : g_bad_wr
        $error("mem_arb: WR_WS must be 1..15");
    end

    mem_arb_st_t            st;
    mem_arb_st_t            st_nxt;
    logic [MEM_ARB_WSW-1:0] cnt;
    logic [MEM_ARB_WSW-1:0] cnt_nxt;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          last_grant;
    logic [IW-1:0]          rr_idx;
    logic [IW-1:0]          g_idx;
    logic                   rr_vld;
    logic                   grant;
    logic                   we_l;
    mem_ctrl_t              strb;
    mem_ctrl_t              strb_nxt;
    logic [N_REQ-1:0]       ack_q;
    logic [7:0]             dato_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             dati_q;
    logic                   busy_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req        (bus.req[N_REQ-1:1]),
        .last_grant (last_grant),
        .grant      (rr_idx),
        .valid      (rr_vld)
    );

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        grant   = 1'b0;
        g_idx   = rr_idx;
        unique case (st)
            IDLE: begin
                if (bus.req[0]) begin
                    grant  = 1'b1;
                    g_idx  = '0;
                    st_nxt = SETUP;
                end else if (rr_vld) begin
                    grant  = 1'b1;
                    st_nxt = SETUP;
                end
            end
            SETUP: begin
                st_nxt  = ACCESS;
                cnt_nxt = we_l ? WR_LD : RD_LD;
            end
            ACCESS: begin
                if (cnt == '0) begin
                    st_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Strobes are derived from the next state so they leave a flop.
    always_comb begin
        strb_nxt    = '0;
        strb_nxt.ce = (st_nxt != IDLE);
        strb_nxt.oe = (st_nxt == ACCESS) && !we_l;
        strb_nxt.we = (st_nxt == ACCESS) && we_l;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
        end else begin
            st <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            last_grant <= IW'(N_REQ - 1);
            we_l       <= 1'b0;
            addr_q     <= '0;
            dati_q     <= '0;
        end else if (grant) begin
            idx    <= g_idx;
            we_l   <= bus.req_we[g_idx];
            addr_q <= bus.req_addr[g_idx];
            dati_q <= bus.req_dati[g_idx];
            // Urgent grants leave the rotation untouched.
            if (!bus.req[0]) begin
                last_grant <= g_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb   <= '0;
            busy_q <= 1'b0;
            ack_q  <= '0;
            dato_q <= '0;
        end else begin
            strb   <= strb_nxt;
            busy_q <= (st_nxt != IDLE);
            ack_q  <= '0;
            if (st_nxt == HOLD) begin
                ack_q[idx] <= 1'b1;
            end
            if (st == ACCESS && cnt == '0 && !we_l) begin
                dato_q <= bus.ram_dato;
            end
        end
    end

    assign bus.ram_ce   = strb.ce & ~rst;
    assign bus.ram_oe   = strb.oe & ~rst;
    assign bus.ram_we   = strb.we & ~rst;
    assign bus.ram_addr = addr_q;
    assign bus.ram_dati = dati_q;
    assign bus.ack      = ack_q;
    assign bus.dato     = dato_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus random request rounds.
// Reference is a transaction-level grant/latency/memory model.
module tb_mem_arb;

    localparam int N     = 4;
    localparam int AW    = 23;
    localparam int RD_WS = 2;
    localparam int WR_WS = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   m_last;

    logic [7:0] ref_mem [256];
    logic [7:0] sram    [256];

    mem_arb_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

    mem_arb #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .RD_WS  (RD_WS),
        .WR_WS  (WR_WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] fill(input int a);
        logic [7:0] b;
        b = 8'(a);
        return b ^ 8'hE0;
    endfunction

    // SRAM model: preset contents, written while ram_we is high.
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = fill(i);
        forever begin
            @(posedge clk);
            if (bus.ram_we === 1'b1)
                sram[bus.ram_addr[7:0]] <= bus.ram_dati;
        end
    end

    assign bus.ram_dato = sram[bus.ram_addr[7:0]];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int p);
        if (p < 0) return 0;
        return bus.req_we[p] ? WR_WS : RD_WS;
    endfunction

    // Urgent port first, else next pending port after the last one.
    function automatic int mdl_pick(input logic [N-1:0] r,
                                    input int last);
        int p;
        if (r[0]) return 0;
        p = last;
        repeat (N - 1) begin
            p = (p == N - 1) ? 1 : p + 1;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom);
        if (a[7:0] == 8'hFF) a[7:0] = 8'h00;
        return a;
    endfunction

    // One isolated access with a cycle-by-cycle strobe timeline.
    task automatic single(input int p, input bit we,
                          input logic [AW-1:0] a,
                          input logic [7:0] d);
        int ws;
        ws = we ? WR_WS : RD_WS;
        bus.req_we[p]   = we;
        bus.req_addr[p] = a;
        bus.req_dati[p] = d;
        bus.req[p]      = 1'b1;
        for (int s = 1; s <= ws + 3; s++) begin
            tick();
            chk("s_ce", bus.ram_ce, s <= ws + 2);
            chk("s_oe", bus.ram_oe, !we && s >= 2 && s <= ws + 1);
            chk("s_we", bus.ram_we, we && s >= 2 && s <= ws + 1);
            chk("s_busy", bus.busy, s <= ws + 2);
            chk("s_ack", bus.ack, (s == ws + 2) ? (32'd1 << p) : 0);
            if (s <= ws + 2) begin
                chk("s_addr", bus.ram_addr, a);
                if (we) chk("s_dati", bus.ram_dati, d);
            end
            if (s == ws + 2) begin
                if (!we) chk("s_dato", bus.dato, ref_mem[a[7:0]]);
                else ref_mem[a[7:0]] = d;
                if (p != 0) m_last = p;
                bus.req[p] = 1'b0;
            end
        end
    endtask

    // Serve pending requests, checking winner order, latency and data.
    task automatic serve(input int n, input bit hold,
                         input int first_p, input int lat0);
        int got;
        int since;
        int budget;
        int ep;
        int exp_lat;
        got    = 0;
        since  = 0;
        budget = 0;
        ep = (first_p >= 0) ? first_p : mdl_pick(bus.req, m_last);
        exp_lat = (lat0 >= 0) ? lat0 : ws_of(ep) + 2;
        while (got < n && budget < 200) begin
            tick();
            since++;
            budget++;
            if (bus.ack !== '0) begin
                chk("ack_port", bus.ack,
                    (ep >= 0) ? (32'd1 << ep) : 0);
                chk("ack_lat", since, exp_lat);
                if (ep >= 0) begin
                    if (!bus.req_we[ep])
                        chk("dato", bus.dato,
                            ref_mem[bus.req_addr[ep][7:0]]);
                    else
                        ref_mem[bus.req_addr[ep][7:0]] =
                            bus.req_dati[ep];
                    if (ep != 0) m_last = ep;
                    if (!hold) bus.req[ep] = 1'b0;
                end
                got++;
                since   = 0;
                ep      = mdl_pick(bus.req, m_last);
                exp_lat = ws_of(ep) + 3;
            end
        end
        if (got < n) chk("ack_count", got, n);
        if (hold) bus.req = '0;
        tick();
        chk("idle_busy", bus.busy, 0);
        chk("idle_ack", bus.ack, 0);
    endtask

    initial begin
        logic [N-1:0] set;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = fill(i);
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_addr = '0;
        bus.req_dati = '0;
        m_last       = N - 1;
        tick();
        tick();
        chk("rst_ce", bus.ram_ce, 0);
        chk("rst_oe", bus.ram_oe, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_dati", bus.ram_dati, 0);
        chk("rst_dato", bus.dato, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        single(2, 1'b0, 23'h012345, 8'h00);
        chk("rd_a5", bus.dato, 8'hA5);
        single(1, 1'b1, 23'h400010, 8'h3C);
        single(1, 1'b0, 23'h400010, 8'h00);
        chk("wr_readback", bus.dato, 8'h3C);

        // Rotation 1,2,3,1 with everyone holding req.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        m_last = N - 1;
        for (int p = 1; p < N; p++) begin
            bus.req_we[p]   = 1'b0;
            bus.req_addr[p] = rand_addr();
        end
        bus.req[3:1] = 3'b111;
        serve(4, 1'b1, -1, -1);

        // Urgent port arrives while port 3 is in ACCESS.
        bus.req_we[3]   = 1'b0;
        bus.req_addr[3] = rand_addr();
        bus.req[3]      = 1'b1;
        tick();
        tick();
        chk("urg_oe", bus.ram_oe, 1);
        bus.req_we[0]   = 1'b0;
        bus.req_addr[0] = rand_addr();
        bus.req_we[1]   = 1'b0;
        bus.req_addr[1] = rand_addr();
        bus.req[0]      = 1'b1;
        bus.req[1]      = 1'b1;
        serve(3, 1'b0, 3, RD_WS);

        // Reset in the middle of a write.
        bus.req_we[1]   = 1'b1;
        bus.req_addr[1] = {15'h0000, 8'hFF};
        bus.req_dati[1] = 8'($urandom);
        bus.req[1]      = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_we", bus.ram_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_we_drop", bus.ram_we, 0);
        chk("rst_ce_drop", bus.ram_ce, 0);
        tick();
        chk("rst_no_ack", bus.ack, 0);
        chk("rst_busy_lo", bus.busy, 0);
        chk("rst_dato_lo", bus.dato, 0);
        for (int p = 2; p < N; p++) begin
            bus.req_we[p]   = 1'b0;
            bus.req_addr[p] = rand_addr();
        end
        bus.req[3:2] = 2'b11;
        rst    = 1'b0;
        m_last = N - 1;
        serve(3, 1'b0, -1, -1);

        // Request withdrawn right after its grant.
        bus.req_we[2]   = 1'b0;
        bus.req_addr[2] = rand_addr();
        bus.req[2]      = 1'b1;
        tick();
        bus.req[2] = 1'b0;
        serve(1, 1'b0, 2, RD_WS + 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_regrant_busy", bus.busy, 0);
            chk("no_regrant_ack", bus.ack, 0);
        end

        // Random request sets, mixed reads and writes.
        for (int r = 0; r < 12; r++) begin
            set = N'($urandom_range(1, (1 << N) - 1));
            for (int p = 0; p < N; p++) begin
                if (set[p]) begin
                    bus.req_we[p]   = 1'($urandom_range(0, 1));
                    bus.req_addr[p] = rand_addr();
                    bus.req_dati[p] = 8'($urandom);
                end
            end
            bus.req = set;
            serve($countones(set), 1'b0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
